hook_launch_control: RTL and testbench

Drives the vertical launch and retract of the miner's hook after the swing stage stops. It sits directly downstream of the swing controller:
- takes the frozen hook position and a start pulse from the top-level game FSM;
- steps the hook down one increment per frame tick until it hits an object or the depth limit, then retracts it at a weight-dependent speed;
- redraws the hook each step through the shared sprite drawer (erase, then draw handshake);
- reports completion and whether an object was grabbed.

---
 rtl/game_pkg.sv | 22 ++
 rtl/hook_launch_control_if.sv | 26 ++
 rtl/hook_launch_datapath.sv | 66 ++++++
 rtl/hook_launch_control.sv | 69 ++++++
 tb/tb_hook_launch_control.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared game constants, FSM state encoding and the retract weight mapping.
package game_pkg;
    localparam logic [8:0] X_MAX    = 9'd303;
    localparam logic [7:0] Y_ORIGIN = 8'd40;
    localparam logic [7:0] Y_MAX    = 8'd230;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_DRAW  = 3'd2,
        S_WAIT  = 3'd3,
        S_ERASE = 3'd4,
        S_CHECK = 3'd5,
        S_STEP  = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    // Heavier objects retract slower; weights 2 and 3 share the slowest speed.
    function automatic logic [1:0] weight_shift(input logic [1:0] weight);
        return (weight == 2'd3) ? 2'd2 : weight;
    endfunction
endpackage

// File: rtl/hook_launch_control_if.sv
// Handshake bundle between the game FSM / sprite drawer and the hook launcher.
interface hook_launch_control_if;
    logic       start_launch;
    logic [8:0] hook_x_in;
    logic [7:0] hook_y_in;
    logic       tick;
    logic       draw_object_done;
    logic       hit;
    logic [1:0] hit_weight;
    logic       start_draw_hook;
    logic       erase_hook;
    logic [8:0] draw_x;
    logic [7:0] draw_y;
    logic       enable_counter;
    logic       launch_done;
    logic       grabbed;

    modport master (
        output start_launch, hook_x_in, hook_y_in, tick, draw_object_done, hit, hit_weight,
        input  start_draw_hook, erase_hook, draw_x, draw_y, enable_counter, launch_done, grabbed
    );
    modport slave (
        input  start_launch, hook_x_in, hook_y_in, tick, draw_object_done, hit, hit_weight,
        output start_draw_hook, erase_hook, draw_x, draw_y, enable_counter, launch_done, grabbed
    );
endinterface

// File: rtl/hook_launch_datapath.sv
// Hook position registers, clamp arithmetic and the turn-around decision.
module hook_launch_datapath #(
    parameter logic [7:0] Y_MAX     = game_pkg::Y_MAX,
    parameter logic [2:0] STEP_DOWN = 3'd2,
    parameter logic [2:0] STEP_UP   = 3'd4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       check,
    input  logic       step,
    input  logic [8:0] hook_x_in,
    input  logic [7:0] hook_y_in,
    input  logic       hit,
    input  logic [1:0] hit_weight,
    output logic [8:0] x,
    output logic [7:0] y,
    output logic       grabbed,
    output logic       at_home
);
    import game_pkg::*;

    logic [7:0] y_org;
    logic       dir_up;
    logic [1:0] weight;
    logic [2:0] up_step;
    logic [8:0] sum9, diff9;
    logic [7:0] y_down, y_up;

    // 9-bit add/subtract: bit 8 flags overflow past 255 or a borrow below 0.
    assign up_step = STEP_UP >> weight_shift(weight);
    assign sum9    = {1'b0, y} + {6'b0, STEP_DOWN};
    assign diff9   = {1'b0, y} - {6'b0, up_step};
    assign y_down  = (sum9 > {1'b0, Y_MAX}) ? Y_MAX : sum9[7:0];
    assign y_up    = (diff9[8] || (diff9[7:0] < y_org)) ? y_org : diff9[7:0];
    assign at_home = dir_up && (y == y_org);

    always_ff @(posedge clk) begin
        if (reset) begin
            x       <= '0;
            y       <= '0;
            y_org   <= '0;
            dir_up  <= 1'b0;
            grabbed <= 1'b0;
            weight  <= '0;
        end else if (load) begin
            x       <= hook_x_in;
            y       <= hook_y_in;
            y_org   <= hook_y_in;
            dir_up  <= 1'b0;
            grabbed <= 1'b0;
            weight  <= '0;
        end else if (check && !dir_up) begin
            // A hit on the deepest row still counts as a catch.
            if (hit) begin
                grabbed <= 1'b1;
                weight  <= hit_weight;
                dir_up  <= 1'b1;
            end else if (y >= Y_MAX) begin
                dir_up  <= 1'b1;
            end
        end else if (step) begin
            y <= dir_up ? y_up : y_down;
        end
    end
endmodule

// File: rtl/hook_launch_control.sv
// Hook launch/retract sequencer: steps the hook and redraws it via erase/draw handshakes.
module hook_launch_control #(
    parameter logic [7:0] Y_MAX     = game_pkg::Y_MAX,
    parameter logic [2:0] STEP_DOWN = 3'd2,
    parameter logic [2:0] STEP_UP   = 3'd4
) (
    input logic                  clk,
    input logic                  reset,
    hook_launch_control_if.slave bus
);
    import game_pkg::*;

    state_t     state, nxt;
    logic       load, check, step, at_home;
    logic [8:0] x;
    logic [7:0] y;
    logic       grabbed;

    hook_launch_datapath #(
        .Y_MAX(Y_MAX), .STEP_DOWN(STEP_DOWN), .STEP_UP(STEP_UP)
    ) u_dp (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .check      (check),
        .step       (step),
        .hook_x_in  (bus.hook_x_in),
        .hook_y_in  (bus.hook_y_in),
        .hit        (bus.hit),
        .hit_weight (bus.hit_weight),
        .x          (x),
        .y          (y),
        .grabbed    (grabbed),
        .at_home    (at_home)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt   = state;
        load  = 1'b0;
        check = 1'b0;
        step  = 1'b0;
        case (state)
            S_IDLE:  if (bus.start_launch) nxt = S_LOAD;
            S_LOAD:  begin load = 1'b1; nxt = S_DRAW; end
            S_DRAW:  if (bus.draw_object_done) nxt = at_home ? S_DONE : S_WAIT;
            S_WAIT:  if (bus.tick) nxt = S_ERASE;
            S_ERASE: if (bus.draw_object_done) nxt = S_CHECK;
            S_CHECK: begin check = 1'b1; nxt = S_STEP; end
            S_STEP:  begin step = 1'b1; nxt = S_DRAW; end
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    logic drawing;
    assign drawing             = (state == S_DRAW) || (state == S_ERASE);
    assign bus.start_draw_hook = drawing;
    assign bus.erase_hook      = (state == S_ERASE);
    assign bus.draw_x          = drawing ? x : 9'd0;
    assign bus.draw_y          = drawing ? y : 8'd0;
    assign bus.enable_counter  = (state == S_WAIT);
    assign bus.launch_done     = (state == S_DONE);
    assign bus.grabbed         = grabbed;
endmodule

// File: tb/tb_hook_launch_control.sv
// Directed bench: model-built scoreboard of erase/draw events checked by a drawer-side monitor.
module tb_hook_launch_control;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hook_launch_control_if bus ();

    hook_launch_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct { bit er; int x; int y; } ev_t;
    ev_t exp_q[$];
    bit  grab_q[$];

    int vectors = 0;
    int miscompares = 0;
    int n_done = 0;
    int lat = 0;
    int hit_at = -1;
    bit hit_en = 0;
    bit tick_en = 1;
    logic drw_done = 1'b0;
    logic stray_done = 1'b0;
    int cur_y = 0;

    assign bus.draw_object_done = drw_done | stray_done;

    task automatic chk(input string tag, input int obs, input int expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Behavioural reference of one launch: every draw/erase event in order, then the grab flag.
    task automatic push_launch(input int x, input int y0, input int hat, input int w, input bit hen);
        int y = y0;
        bit up = 0;
        bit g = 0;
        int wt = 0;
        int s;
        for (int k = 0; k < 1000; k++) begin
            exp_q.push_back('{0, x, y});
            if (up && y == y0) break;
            exp_q.push_back('{1, x, y});
            if (!up) begin
                if (hen && y == hat) begin g = 1; wt = w; up = 1; end
                else if (y >= 230) up = 1;
            end
            if (!up) y = (y + 2 > 230) ? 230 : y + 2;
            else begin
                s = (wt == 0) ? 4 : (wt == 1) ? 2 : 1;
                y = (y - s < y0) ? y0 : y - s;
            end
        end
        grab_q.push_back(g);
    endtask

    task automatic launch(input int x, input int y);
        @(negedge clk);
        bus.hook_x_in = 9'(x);
        bus.hook_y_in = 8'(y);
        bus.start_launch = 1'b1;
        @(negedge clk);
        bus.start_launch = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int start = n_done;
        int k = 0;
        while (n_done == start && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("launch_done_seen", int'(n_done > start), 1);
        chk("sb_drained", exp_q.size(), 0);
    endtask

    task automatic wait_draw_y(input int yv, input int budget);
        int k = 0;
        bit found = 0;
        while (!found && k < budget) begin
            @(negedge clk);
            found = bus.start_draw_hook && !bus.erase_hook && (int'(bus.draw_y) == yv);
            k++;
        end
        chk("reached_draw_y", int'(found), 1);
    endtask

    // Frame tick every 4 cycles, gated so stray stimulus can be parked inside WAIT.
    initial begin
        int cyc = 0;
        bus.tick = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.tick = tick_en && (cyc % 4 == 3);
            cyc++;
        end
    end

    // Sprite drawer and object table: done after `lat` busy cycles, hit when hook sits on hit_at.
    initial begin
        int cnt = 0;
        bus.hit = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus.start_draw_hook) begin
                cur_y = int'(bus.draw_y);
                if (cnt >= lat) begin drw_done = 1'b1; cnt = 0; end
                else begin drw_done = 1'b0; cnt++; end
            end else begin
                drw_done = 1'b0;
                cnt = 0;
            end
            bus.hit = hit_en && (cur_y == hit_at);
        end
    end

    // Monitor: every draw/erase cycle must match the scoreboard head; pop on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.start_draw_hook) begin
                    chk("sb_has_event", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        chk("draw_x", int'(bus.draw_x), exp_q[0].x);
                        chk("draw_y", int'(bus.draw_y), exp_q[0].y);
                        chk("erase_hook", int'(bus.erase_hook), int'(exp_q[0].er));
                        if (bus.draw_object_done) void'(exp_q.pop_front());
                    end
                end else begin
                    chk("idle_draw_xy", int'(bus.draw_x) + int'(bus.draw_y) + int'(bus.erase_hook), 0);
                end
                if (bus.launch_done) begin
                    n_done++;
                    chk("done_expected", int'(grab_q.size() > 0), 1);
                    if (grab_q.size() > 0) chk("grabbed_at_done", int'(bus.grabbed), int'(grab_q.pop_front()));
                end
            end
        end
    end

    initial begin
        int d0;
        bus.start_launch = 1'b0;
        bus.hook_x_in = '0;
        bus.hook_y_in = '0;
        bus.hit_weight = '0;
        repeat (3) @(negedge clk);
        chk("rst_start_draw", int'(bus.start_draw_hook), 0);
        chk("rst_enable_cnt", int'(bus.enable_counter), 0);
        chk("rst_launch_done", int'(bus.launch_done), 0);
        chk("rst_grabbed", int'(bus.grabbed), 0);
        chk("rst_draw_xy", int'(bus.draw_x) + int'(bus.draw_y), 0);
        reset = 1'b0;

        // Reset mid-descent at y = 60.
        push_launch(146, 40, -1, 0, 0);
        launch(146, 40);
        wait_draw_y(60, 1000);
        #2;
        reset = 1'b1;
        exp_q.delete();
        grab_q.delete();
        @(negedge clk);
        chk("midrst_start_draw", int'(bus.start_draw_hook), 0);
        chk("midrst_erase", int'(bus.erase_hook), 0);
        chk("midrst_enable_cnt", int'(bus.enable_counter), 0);
        chk("midrst_draw_y", int'(bus.draw_y), 0);
        chk("midrst_grabbed", int'(bus.grabbed), 0);
        reset = 1'b0;

        // Relaunch from a new origin, hit on the way down, weight 0.
        hit_en = 1; hit_at = 60; bus.hit_weight = 2'd0;
        push_launch(120, 50, 60, 0, 1);
        launch(120, 50);
        wait_done(1000);

        // Full no-hit descent to Y_MAX and retract.
        hit_en = 0; hit_at = -1;
        push_launch(146, 40, -1, 0, 0);
        launch(146, 40);
        wait_done(4000);
        repeat (3) @(negedge clk);
        chk("grabbed_hold_nohit", int'(bus.grabbed), 0);

        // Hit at 100, weight 1.
        hit_en = 1; hit_at = 100; bus.hit_weight = 2'd1;
        push_launch(146, 40, 100, 1, 1);
        launch(146, 40);
        wait_done(3000);
        repeat (5) @(negedge clk);
        chk("grabbed_hold_hit", int'(bus.grabbed), 1);

        // Hit at 43, weight 3: retract by one pixel down to the origin.
        hit_at = 43; bus.hit_weight = 2'd3;
        push_launch(146, 39, 43, 3, 1);
        launch(146, 39);
        wait_done(500);

        // Near-zero origin: retract step would borrow below 0 in 8 bits.
        hit_at = 3; bus.hit_weight = 2'd0;
        push_launch(10, 1, 3, 0, 1);
        launch(10, 1);
        wait_done(500);

        // Hit on the deepest row, plus stray start_launch and done while parked in WAIT.
        hit_at = 230; bus.hit_weight = 2'd2;
        push_launch(146, 200, 230, 2, 1);
        launch(146, 200);
        wait_draw_y(220, 1000);
        tick_en = 0;
        begin
            int k = 0;
            while (!bus.enable_counter && k < 50) begin @(negedge clk); k++; end
            chk("parked_in_wait", int'(bus.enable_counter), 1);
        end
        bus.hook_y_in = 8'd10;
        bus.start_launch = 1'b1;
        stray_done = 1'b1;
        @(negedge clk);
        chk("wait_ignores_stray", int'(bus.enable_counter), 1);
        bus.start_launch = 1'b0;
        stray_done = 1'b0;
        tick_en = 1;
        d0 = n_done;
        wait_done(2000);
        repeat (20) @(negedge clk);
        chk("single_launch_done", n_done, d0 + 1);

        // Origin beyond Y_MAX turns around on the first CHECK.
        hit_en = 0; hit_at = -1;
        push_launch(100, 232, -1, 0, 0);
        launch(100, 232);
        wait_done(200);

        // Slow drawer: 50 busy cycles per handshake, outputs held stable meanwhile.
        lat = 50;
        push_launch(146, 220, -1, 0, 0);
        launch(146, 220);
        wait_done(5000);
        lat = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
